// File: rtl/threshold_alarm_monitor.sv
// Hysteresis alarm on a filtered sample stream with N-sample confirm,
// peak tracking and a saturating episode counter.
module threshold_alarm_monitor #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] thr_high,
  input  logic [DATA_W-1:0] thr_low,
  input  logic [CNT_W-1:0]  confirm_n,
  input  logic              clear,
  output logic              alarm,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [DATA_W-1:0] peak,
  output logic [7:0]        episode_cnt
);

  typedef enum logic [1:0] {
    LOW,
    ARM_HI,
    HIGH,
    ARM_LO
  } state_t;

  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_d;
  logic [CNT_W:0]   eff_n;
  logic [CNT_W:0]   run_inc;
  logic             sample;
  logic             hi_hit;
  logic             lo_hit;
  logic             rise_d;
  logic             fall_d;

  assign sample  = enable & din_valid;
  assign hi_hit  = din >= thr_high;
  assign lo_hit  = din <= thr_low;
  // confirm_n of zero behaves as a single-sample confirm
  assign eff_n   = (confirm_n == '0) ? ONE : {1'b0, confirm_n};
  assign run_inc = {1'b0, run_q} + ONE;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (clear) begin
      state_d = LOW;
      run_d   = '0;
    end else if (sample) begin
      unique case (state_q)
        LOW: begin
          if (hi_hit) begin
            if (eff_n == ONE) begin
              state_d = HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = ARM_HI;
              run_d   = ONE[CNT_W-1:0];
            end
          end
        end
        ARM_HI: begin
          if (!hi_hit) begin
            state_d = LOW;
            run_d   = '0;
          end else if (run_inc >= eff_n) begin
            state_d = HIGH;
            run_d   = '0;
            rise_d  = 1'b1;
          end else begin
            run_d = run_inc[CNT_W-1:0];
          end
        end
        HIGH: begin
          if (lo_hit) begin
            if (eff_n == ONE) begin
              state_d = LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = ARM_LO;
              run_d   = ONE[CNT_W-1:0];
            end
          end
        end
        ARM_LO: begin
          if (!lo_hit) begin
            state_d = HIGH;
            run_d   = '0;
          end else if (run_inc >= eff_n) begin
            state_d = LOW;
            run_d   = '0;
            fall_d  = 1'b1;
          end else begin
            run_d = run_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = LOW;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOW;
      run_q      <= '0;
      alarm      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      alarm      <= (state_d == HIGH) || (state_d == ARM_LO);
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak        <= '0;
      episode_cnt <= '0;
    end else if (clear) begin
      peak        <= '0;
      episode_cnt <= '0;
    end else begin
      if (sample && (din > peak)) begin
        peak <= din;
      end
      if (rise_d && (episode_cnt != 8'hff)) begin
        episode_cnt <= episode_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_threshold_alarm_monitor.sv
// Directed-vector bench for threshold_alarm_monitor.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_threshold_alarm_monitor;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] din;
  logic        din_valid;
  logic [15:0] thr_high;
  logic [15:0] thr_low;
  logic [3:0]  confirm_n;
  logic        clear;
  logic        alarm;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [15:0] peak;
  logic [7:0]  episode_cnt;

  int n_vec;
  int n_err;

  threshold_alarm_monitor #(
    .DATA_W(16),
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .din        (din),
    .din_valid  (din_valid),
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .confirm_n  (confirm_n),
    .clear      (clear),
    .alarm      (alarm),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .peak       (peak),
    .episode_cnt(episode_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic a, input logic r, input logic f,
                      input logic [15:0] p, input logic [7:0] e);
    check({tag, ".alarm"}, {31'd0, alarm}, {31'd0, a});
    check({tag, ".rise"}, {31'd0, rise_pulse}, {31'd0, r});
    check({tag, ".fall"}, {31'd0, fall_pulse}, {31'd0, f});
    check({tag, ".peak"}, {16'd0, peak}, {16'd0, p});
    check({tag, ".ep"}, {24'd0, episode_cnt}, {24'd0, e});
  endtask

  task automatic samp(input logic [15:0] v);
    din       = v;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    thr_high  = 16'd100;
    thr_low   = 16'd50;
    confirm_n = 4'd3;
    clear     = 1'b0;
    #22;
    outs("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    outs("post_rst", 0, 0, 0, 0, 0);

    // three qualifying samples confirm the rise
    samp(120); outs("r1", 0, 0, 0, 120, 0);
    samp(120); outs("r2", 0, 0, 0, 120, 0);
    samp(120); outs("r3", 1, 1, 0, 120, 1);
    idle();    outs("r4", 1, 0, 0, 120, 1);

    // fall with N=2 and one broken run
    confirm_n = 4'd2;
    samp(40);  outs("f1", 1, 0, 0, 120, 1);
    samp(60);  outs("f2", 1, 0, 0, 120, 1);
    samp(40);  outs("f3", 1, 0, 0, 120, 1);
    samp(40);  outs("f4", 0, 0, 1, 120, 1);
    idle();    outs("f5", 0, 0, 0, 120, 1);

    // clear from LOW, then an interrupted arm
    clear = 1'b1;
    idle();
    clear = 1'b0;
    outs("clr", 0, 0, 0, 0, 0);
    confirm_n = 4'd3;
    samp(120); samp(120);
    samp(80);  outs("brk1", 0, 0, 0, 120, 0);
    samp(120); outs("brk2", 0, 0, 0, 120, 0);

    // clear beats a coincident qualifying sample while in ARM_HI
    clear = 1'b1;
    samp(150);
    clear = 1'b0;
    outs("clr_arm", 0, 0, 0, 0, 0);
    samp(120);
    samp(120); outs("rearm", 0, 0, 0, 120, 0);
    enable = 1'b0;
    samp(200); samp(200); samp(200);
    outs("dis", 0, 0, 0, 120, 0);
    enable = 1'b1;
    samp(120); outs("en_rise", 1, 1, 0, 120, 1);
    enable = 1'b0;
    samp(200); outs("dis_pulse", 1, 0, 0, 120, 1);
    enable = 1'b1;

    // N=0 acts as 1; equality satisfies the threshold
    clear = 1'b1;
    idle();
    clear = 1'b0;
    outs("clr_hi", 0, 0, 0, 0, 0);
    confirm_n = 4'd0;
    samp(100); outs("n0_rise", 1, 1, 0, 100, 1);
    samp(50);  outs("n0_fall", 0, 0, 1, 100, 1);

    // episode counter saturation
    confirm_n = 4'd1;
    for (int i = 0; i < 300; i++) begin
      samp(200);
      samp(10);
    end
    outs("sat", 0, 0, 1, 200, 255);

    // reset in ARM_LO clears everything at once
    confirm_n = 4'd3;
    samp(200); samp(200); samp(200);
    samp(10);  outs("armlo", 1, 0, 0, 200, 255);
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    samp(10);  samp(10);
    outs("restart_lo", 0, 0, 0, 10, 0);
    samp(200); samp(200);
    outs("restart_arm", 0, 0, 0, 200, 0);
    samp(200); outs("restart_hi", 1, 1, 0, 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/threshold_alarm_monitor.md
THRESHOLD_ALARM_MONITOR -- requirements
Module: threshold_alarm_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample and threshold width.
REQ-002 SHALL have parameter CNT_W, default 4, width of the confirm count.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  when 0, samples are ignored and all state holds.
REQ-007 din  input  DATA_W  filtered sample, unsigned; driven by the upstream moving-average dout.
REQ-008 din_valid  input  1  one-cycle sample strobe; driven by the upstream moving-average output_pulse.
REQ-009 thr_high  input  DATA_W  alarm-set threshold, unsigned.
REQ-010 thr_low  input  DATA_W  alarm-clear threshold, unsigned.
REQ-011 confirm_n  input  CNT_W  number of consecutive qualifying samples needed; 0 is treated as 1.
REQ-012 clear  input  1  synchronous clear of FSM, peak and counters.
REQ-013 alarm  output  1  level; 1 in state HIGH and ARM_LO.
REQ-014 rise_pulse  output  1  one-cycle pulse on the LOW-to-HIGH alarm transition.
REQ-015 fall_pulse  output  1  one-cycle pulse on the HIGH-to-LOW alarm transition.
REQ-016 peak  output  DATA_W  maximum din sampled since reset or clear.
REQ-017 episode_cnt  output  8  count of rise events; saturates at 255.

Function
REQ-018 A "sample" SHALL be a clock edge with enable=1 and din_valid=1; no other edge SHALL change FSM, run_cnt, peak or episode_cnt.
REQ-019 FSM SHALL have states LOW, ARM_HI, HIGH, ARM_LO plus an internal run counter run_cnt (CNT_W bits).
REQ-020 LOW: sample with din >= thr_high -> ARM_HI with run_cnt=1, or -> HIGH directly if effective N is 1; otherwise stay in LOW.
REQ-021 ARM_HI: sample with din >= thr_high -> run_cnt+1; when run_cnt+1 >= effective N -> HIGH and run_cnt=0; sample with din < thr_high -> LOW and run_cnt=0.
REQ-022 HIGH: sample with din <= thr_low -> ARM_LO with run_cnt=1, or -> LOW directly if effective N is 1; otherwise stay in HIGH.
REQ-023 ARM_LO: sample with din <= thr_low -> run_cnt+1; when run_cnt+1 >= N -> LOW; sample with din > thr_low -> HIGH and run_cnt=0.
REQ-024 Thresholds and confirm_n SHALL be used combinationally at each sample, not latched; use >= so that lowering N mid-arm completes at the next qualifying sample.
REQ-025 rise_pulse and fall_pulse SHALL be registered, asserted high for exactly one cycle after the edge that enters HIGH or LOW from the ARM states or directly.
REQ-026 alarm SHALL be registered and SHALL change on the same edge as the corresponding pulse.
REQ-027 Latency from the Nth qualifying din_valid edge to alarm/pulse visible SHALL be 1 cycle.
REQ-028 peak SHALL update to din on any sample with din > peak.
REQ-029 episode_cnt SHALL increment on each rise and hold at 255.
REQ-030 Back-to-back din_valid on every cycle SHALL be supported with no lost samples.
REQ-031 thr_low >= thr_high SHALL NOT be trapped; thresholds are applied as-is, and oscillation is the caller's responsibility.
REQ-032 clear=1 SHALL force LOW, run_cnt=0, alarm=0, peak=0 and episode_cnt=0 on the next edge, and SHALL NOT emit fall_pulse.
REQ-033 clear SHALL have priority over a coincident sample, which is discarded; clear SHALL act regardless of enable.
REQ-034 When enable=0, the pulses SHALL deassert the next cycle and alarm, peak and episode_cnt SHALL hold.

Reset
REQ-035 rst_n low SHALL immediately force LOW, run_cnt=0, alarm=0, rise_pulse=0, fall_pulse=0, peak=0, episode_cnt=0.
REQ-036 Reset asserted mid-ARM SHALL discard partial counts, and the first samples after release SHALL restart counting from LOW.

Verification
REQ-037 Set thr_high=100, thr_low=50, N=3; send samples 120,120,120 -> rise_pulse one cycle after the 3rd sample, alarm=1, episode_cnt=1.
REQ-038 Same thresholds; send 120,120,80,120 -> no rise (FSM back to LOW at 80), alarm=0; peak=120.
REQ-039 In HIGH with N=2, send 40,60,40,40 -> LOW only after the final 40; exactly one fall_pulse.
REQ-040 Set N=0, thr_high=100; send 100 -> immediate HIGH and rise_pulse (N treated as 1, >= comparison).
REQ-041 In ARM_HI, assert clear coincident with a qualifying sample -> LOW, peak=0, episode_cnt=0, no pulses; set enable=0 with samples at 200 -> no state change.
REQ-042 Send 300 rise/fall episodes -> episode_cnt saturates at 255; rst_n pulse mid-ARM -> all outputs 0 immediately.
